// File: rtl/itof_pipeline_if.sv
// Issue/completion bundle for the integer-to-float pipeline.
// master drives the issue side and observes completions; slave is the converter.
interface itof_pipeline_if #(
    parameter int unsigned TAG_WIDTH = 2
);
    logic                 stall_i;
    logic                 flush_i;
    logic                 valid_i;
    logic                 signed_i;
    logic [TAG_WIDTH-1:0] tag_i;
    logic [31:0]          operand_i;
    logic                 valid_o;
    logic [TAG_WIDTH-1:0] tag_o;
    logic [31:0]          result_o;
    logic                 inexact_o;

    modport master (
        output stall_i, flush_i, valid_i, signed_i, tag_i, operand_i,
        input  valid_o, tag_o, result_o, inexact_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, signed_i, tag_i, operand_i,
        output valid_o, tag_o, result_o, inexact_o
    );
endinterface

// File: rtl/itof_pipeline.sv
// Three-stage 32-bit integer to IEEE-754 single-precision converter with
// round-to-nearest-even, global stall, flush and a pass-through tag.
module itof_pipeline #(
    parameter int unsigned TAG_WIDTH = 2
) (
    input logic           clk,
    input logic           reset_n,
    itof_pipeline_if.slave bus
);

    // Stage 1: sign and magnitude
    logic                 s1_valid;
    logic                 s1_sign;
    logic [31:0]          s1_mag;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic                 s1_sign_d;
    logic [31:0]          s1_mag_d;

    always_comb begin
        s1_sign_d = bus.signed_i & bus.operand_i[31];
        s1_mag_d  = s1_sign_d ? (~bus.operand_i + 32'd1) : bus.operand_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_tag   <= '0;
        end else begin
            if (bus.flush_i)
                s1_valid <= 1'b0;
            else if (!bus.stall_i)
                s1_valid <= bus.valid_i;
            if (!bus.stall_i) begin
                s1_sign <= s1_sign_d;
                s1_mag  <= s1_mag_d;
                s1_tag  <= bus.tag_i;
            end
        end
    end

    // Stage 2: normalise via binary-search leading-zero count
    logic                 s2_valid;
    logic                 s2_sign;
    logic                 s2_zero;
    logic [31:0]          s2_norm;
    logic [7:0]           s2_exp;
    logic [TAG_WIDTH-1:0] s2_tag;

    logic [4:0]           lz;
    logic [31:0]          norm_d;
    logic [7:0]           exp_d;

    always_comb begin
        lz     = '0;
        norm_d = s1_mag;
        if (norm_d[31:16] == 16'd0) begin
            lz[4]  = 1'b1;
            norm_d = norm_d << 16;
        end
        if (norm_d[31:24] == 8'd0) begin
            lz[3]  = 1'b1;
            norm_d = norm_d << 8;
        end
        if (norm_d[31:28] == 4'd0) begin
            lz[2]  = 1'b1;
            norm_d = norm_d << 4;
        end
        if (norm_d[31:30] == 2'd0) begin
            lz[1]  = 1'b1;
            norm_d = norm_d << 2;
        end
        if (norm_d[31] == 1'b0) begin
            lz[0]  = 1'b1;
            norm_d = norm_d << 1;
        end
        exp_d = 8'd158 - {3'd0, lz};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_norm  <= '0;
            s2_exp   <= '0;
            s2_tag   <= '0;
        end else begin
            if (bus.flush_i)
                s2_valid <= 1'b0;
            else if (!bus.stall_i)
                s2_valid <= s1_valid;
            if (!bus.stall_i) begin
                s2_sign <= s1_sign;
                s2_zero <= (s1_mag == 32'd0);
                s2_norm <= norm_d;
                s2_exp  <= exp_d;
                s2_tag  <= s1_tag;
            end
        end
    end

    // Stage 3: round to nearest even and pack into the output registers
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic        carry;
    logic [22:0] mant_r;
    logic [7:0]  exp_r;
    logic [31:0] result_d;
    logic        inexact_d;

    always_comb begin
        mant            = s2_norm[30:8];
        guard           = s2_norm[7];
        sticky          = |s2_norm[6:0];
        round_up        = guard & (sticky | mant[0]);
        {carry, mant_r} = {1'b0, mant} + {23'd0, round_up};
        exp_r           = s2_exp + {7'd0, carry};
        if (s2_zero) begin
            result_d  = '0;
            inexact_d = 1'b0;
        end else begin
            result_d  = {s2_sign, exp_r, mant_r};
            inexact_d = guard | sticky;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.valid_o   <= 1'b0;
            bus.tag_o     <= '0;
            bus.result_o  <= '0;
            bus.inexact_o <= 1'b0;
        end else begin
            if (bus.flush_i)
                bus.valid_o <= 1'b0;
            else if (!bus.stall_i)
                bus.valid_o <= s2_valid;
            if (!bus.stall_i) begin
                bus.tag_o     <= s2_tag;
                bus.result_o  <= result_d;
                bus.inexact_o <= inexact_d;
            end
        end
    end

endmodule

// File: tb/tb_itof_pipeline.sv
// Scoreboard bench for itof_pipeline: expectations are queued at issue time
// and popped as completions appear on valid_o.
module tb_itof_pipeline;

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] result;
        logic        inexact;
    } exp_t;

    logic clk;
    logic reset_n;
    int   pass_cnt;
    int   total_cnt;
    exp_t exp_q[$];

    itof_pipeline_if #(.TAG_WIDTH(2)) bus();

    itof_pipeline #(.TAG_WIDTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion by MSB search and integer remainder comparison.
    function automatic exp_t model(input logic [1:0] tg, input logic sgn, input logic [31:0] op);
        exp_t        r;
        logic        neg;
        logic [31:0] mag;
        logic [31:0] q;
        logic [31:0] rem;
        logic [31:0] half;
        logic [7:0]  e;
        int          p;
        int          sh;
        logic        rnd;
        neg = sgn && op[31];
        mag = neg ? (32'd0 - op) : op;
        r.tag = tg;
        if (mag == 32'd0) begin
            r.result  = 32'd0;
            r.inexact = 1'b0;
            return r;
        end
        p = 31;
        while (!mag[p]) p--;
        if (p <= 23) begin
            q = mag << (23 - p);
            r.result  = {neg, 8'(127 + p), q[22:0]};
            r.inexact = 1'b0;
            return r;
        end
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag & ((32'd1 << sh) - 32'd1);
        half = 32'd1 << (sh - 1);
        rnd  = (rem > half) || ((rem == half) && q[0]);
        q    = q + {31'd0, rnd};
        e    = 8'(127 + p);
        if (q[24]) begin
            q = q >> 1;
            e = e + 8'd1;
        end
        r.result  = {neg, e, q[22:0]};
        r.inexact = (rem != 32'd0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sgn, input logic [1:0] tg, input logic [31:0] op);
        bus.valid_i   = v;
        bus.signed_i  = sgn;
        bus.tag_i     = tg;
        bus.operand_i = op;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'd0);
        tick();
        tick();
        total_cnt++;
        if (bus.valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.result_o !== 32'd0) $display("FAIL reset_result: got %h want 00000000", bus.result_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.tag_o !== 2'd0) $display("FAIL reset_tag: got %0d want 0", bus.tag_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.inexact_o !== 1'b0) $display("FAIL reset_inexact: got %b want 0", bus.inexact_o);
        else pass_cnt++;
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        logic [31:0] ops[3];
        exp_t        e;
        int          first_idx;
        int          run_len;
        ops = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002};
        exp_q.push_back('{tag: 2'd0, result: 32'h0000_0000, inexact: 1'b0});
        exp_q.push_back('{tag: 2'd1, result: 32'h3F80_0000, inexact: 1'b0});
        exp_q.push_back('{tag: 2'd2, result: 32'h4000_0000, inexact: 1'b0});
        first_idx = -1;
        run_len   = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 3) drive(1'b1, 1'b0, 2'(i), ops[i]);
            else drive(1'b0, 1'b0, 2'd0, 32'd0);
            tick();
            if (bus.valid_o) begin
                if (first_idx < 0) first_idx = i;
                run_len++;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unsigned_extra: got tag=%0d result=%h, want no output", bus.tag_o, bus.result_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.tag_o, bus.result_o, bus.inexact_o} !== e)
                        $display("FAIL unsigned_out: got tag=%0d result=%h inexact=%b, want tag=%0d result=%h inexact=%b",
                                 bus.tag_o, bus.result_o, bus.inexact_o, e.tag, e.result, e.inexact);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (first_idx !== 2) $display("FAIL unsigned_latency: got first valid after edge %0d want 2", first_idx);
        else pass_cnt++;
        total_cnt++;
        if (run_len !== 3) $display("FAIL unsigned_run: got %0d valid cycles want 3", run_len);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL unsigned_drain: got %0d missing results want 0", exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_table(input string name, input logic sgn, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] c,
                              input exp_t ea, input exp_t eb, input exp_t ec);
        exp_t e;
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        exp_q.push_back(ec);
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: drive(1'b1, sgn, ea.tag, a);
                1: drive(1'b1, sgn, eb.tag, b);
                2: drive(1'b1, sgn, ec.tag, c);
                default: drive(1'b0, 1'b0, 2'd0, 32'd0);
            endcase
            tick();
            if (bus.valid_o) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s_extra: got tag=%0d result=%h, want no output", name, bus.tag_o, bus.result_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.tag_o, bus.result_o, bus.inexact_o} !== e)
                        $display("FAIL %s_out: got tag=%0d result=%h inexact=%b, want tag=%0d result=%h inexact=%b",
                                 name, bus.tag_o, bus.result_o, bus.inexact_o, e.tag, e.result, e.inexact);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d missing results want 0", name, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_stall();
        exp_t e0, e1, e2;
        e0 = model(2'd0, 1'b0, 32'd10);
        e1 = model(2'd1, 1'b0, 32'd20);
        e2 = model(2'd2, 1'b0, 32'd30);
        drive(1'b1, 1'b0, 2'd0, 32'd10); tick();
        drive(1'b1, 1'b0, 2'd1, 32'd20); tick();
        drive(1'b1, 1'b0, 2'd2, 32'd30); tick();
        total_cnt++;
        if ({bus.valid_o, bus.tag_o, bus.result_o, bus.inexact_o} !== {1'b1, e0})
            $display("FAIL stall_first: got v=%b tag=%0d result=%h want v=1 tag=0 result=%h",
                     bus.valid_o, bus.tag_o, bus.result_o, e0.result);
        else pass_cnt++;
        bus.stall_i = 1'b1;
        drive(1'b1, 1'b0, 2'd3, 32'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if ({bus.valid_o, bus.tag_o, bus.result_o, bus.inexact_o} !== {1'b1, e0})
                $display("FAIL stall_frozen: cycle %0d got v=%b tag=%0d result=%h want v=1 tag=0 result=%h",
                         i, bus.valid_o, bus.tag_o, bus.result_o, e0.result);
            else pass_cnt++;
        end
        bus.stall_i = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'd0);
        tick();
        total_cnt++;
        if ({bus.valid_o, bus.tag_o, bus.result_o, bus.inexact_o} !== {1'b1, e1})
            $display("FAIL stall_tag1: got v=%b tag=%0d result=%h want v=1 tag=1 result=%h",
                     bus.valid_o, bus.tag_o, bus.result_o, e1.result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.valid_o, bus.tag_o, bus.result_o, bus.inexact_o} !== {1'b1, e2})
            $display("FAIL stall_tag2: got v=%b tag=%0d result=%h want v=1 tag=2 result=%h",
                     bus.valid_o, bus.tag_o, bus.result_o, e2.result);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if (bus.valid_o !== 1'b0)
                $display("FAIL stall_dropped: got v=%b tag=%0d result=%h want no output", bus.valid_o, bus.tag_o, bus.result_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        exp_t e;
        int   post_idx;
        // Only the oldest conversion has reached the output register before the flush edge.
        exp_q.push_back(model(2'd0, 1'b0, 32'd100));
        exp_q.push_back(model(2'd3, 1'b1, 32'hFFFF_FFF9));
        post_idx = -1;
        for (int i = 0; i < 10; i++) begin
            bus.flush_i = 1'b0;
            case (i)
                0: drive(1'b1, 1'b0, 2'd0, 32'd100);
                1: drive(1'b1, 1'b0, 2'd1, 32'd200);
                2: drive(1'b1, 1'b0, 2'd2, 32'd300);
                3: begin bus.flush_i = 1'b1; drive(1'b1, 1'b0, 2'd1, 32'd99); end
                4: drive(1'b1, 1'b1, 2'd3, 32'hFFFF_FFF9);
                default: drive(1'b0, 1'b0, 2'd0, 32'd0);
            endcase
            tick();
            if (bus.valid_o) begin
                if (bus.tag_o == 2'd3) post_idx = i;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL flush_killed: got tag=%0d result=%h, want no output", bus.tag_o, bus.result_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.tag_o, bus.result_o, bus.inexact_o} !== e)
                        $display("FAIL flush_out: got tag=%0d result=%h inexact=%b, want tag=%0d result=%h inexact=%b",
                                 bus.tag_o, bus.result_o, bus.inexact_o, e.tag, e.result, e.inexact);
                    else pass_cnt++;
                end
            end
        end
        bus.flush_i = 1'b0;
        total_cnt++;
        if (post_idx !== 6) $display("FAIL flush_post_latency: got edge %0d want 6", post_idx);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL flush_drain: got %0d missing results want 0", exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic        v;
        logic        sgn;
        logic        stl;
        logic [1:0]  tg;
        logic [31:0] op;
        for (int i = 0; i < 70; i++) begin
            if (i < 60) begin
                v   = ($urandom_range(0, 3) != 0);
                sgn = $urandom_range(0, 1) == 1;
                stl = ($urandom_range(0, 6) == 0);
                tg  = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: op = $urandom;
                    1: op = 32'($urandom_range(0, 300));
                    2: op = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 2)) - 32'd1;
                    default: op = 32'hFFFF_FFFF - 32'($urandom_range(0, 400));
                endcase
            end else begin
                v = 1'b0; sgn = 1'b0; stl = 1'b0; tg = 2'd0; op = 32'd0;
            end
            bus.stall_i = stl;
            drive(v, sgn, tg, op);
            if (v && !stl) exp_q.push_back(model(tg, sgn, op));
            tick();
            if (bus.valid_o && !stl) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra: got tag=%0d result=%h, want no output", bus.tag_o, bus.result_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.tag_o, bus.result_o, bus.inexact_o} !== e)
                        $display("FAIL b2b_out: got tag=%0d result=%h inexact=%b, want tag=%0d result=%h inexact=%b",
                                 bus.tag_o, bus.result_o, bus.inexact_o, e.tag, e.result, e.inexact);
                    else pass_cnt++;
                end
            end
        end
        bus.stall_i = 1'b0;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d missing results want 0", exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        exp_t e0;
        int   spurious;
        e0 = model(2'd1, 1'b0, 32'd1000);
        drive(1'b1, 1'b0, 2'd1, 32'd1000); tick();
        drive(1'b1, 1'b0, 2'd2, 32'd2000); tick();
        drive(1'b1, 1'b0, 2'd3, 32'd3000); tick();
        total_cnt++;
        if ({bus.valid_o, bus.tag_o, bus.result_o, bus.inexact_o} !== {1'b1, e0})
            $display("FAIL areset_pre: got v=%b tag=%0d result=%h want v=1 tag=1 result=%h",
                     bus.valid_o, bus.tag_o, bus.result_o, e0.result);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.valid_o, bus.result_o, bus.tag_o, bus.inexact_o} !== 36'd0)
            $display("FAIL areset_clear: got v=%b result=%h tag=%0d inexact=%b want all 0",
                     bus.valid_o, bus.result_o, bus.tag_o, bus.inexact_o);
        else pass_cnt++;
        drive(1'b0, 1'b0, 2'd0, 32'd0);
        tick();
        #3 reset_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.valid_o !== 1'b0) spurious++;
        end
        total_cnt++;
        if (spurious != 0) $display("FAIL areset_spurious: got %0d valid cycles want 0", spurious);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_unsigned();
        test_table("signed", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                   '{tag: 2'd1, result: 32'hBF80_0000, inexact: 1'b0},
                   '{tag: 2'd2, result: 32'hCF00_0000, inexact: 1'b0},
                   '{tag: 2'd3, result: 32'h4F00_0000, inexact: 1'b1});
        test_table("rne", 1'b0, 32'h0100_0001, 32'h0100_0003, 32'hFFFF_FFFF,
                   '{tag: 2'd2, result: 32'h4B80_0000, inexact: 1'b1},
                   '{tag: 2'd0, result: 32'h4B80_0002, inexact: 1'b1},
                   '{tag: 2'd3, result: 32'h4F80_0000, inexact: 1'b1});
        test_stall();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
